// File: rtl/mest_pro_fetch_stack.sv
// MEST Pro instruction fetch stage: program counter, req/ack ROM fetch with wait states,
// and a return-address stack of configurable depth for nested calls.
module mest_pro_fetch_stack #(
   parameter int unsigned OP_CODE_SIZE     = 4,
   parameter int unsigned INSTRUCTION_SIZE = OP_CODE_SIZE + 24,
   parameter int unsigned ROM_DEPTH        = 256,
   parameter int unsigned STACK_DEPTH      = 4,
   localparam int unsigned PC_W            = $clog2(ROM_DEPTH),
   localparam int unsigned SP_W            = $clog2(STACK_DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        i_reset,
   input  logic                        idle_state,
   input  logic                        fetch_state,
   input  logic                        exec_state,
   input  logic                        jump,
   input  logic                        call,
   input  logic                        return_pc,
   input  logic [PC_W-1:0]             const_K,
   output logic [INSTRUCTION_SIZE-1:0] decode_reg,
   output logic                        fetch_done,
   output logic [SP_W-1:0]             o_stack_level,
   output logic                        o_stack_overflow,
   output logic                        o_stack_underflow,
   output logic                        o_req,
   output logic [PC_W-1:0]             o_prog_counter,
   input  logic                        i_ack,
   input  logic [INSTRUCTION_SIZE-1:0] i_instruction
);

   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } fetch_state_t;

   fetch_state_t     state;
   logic [PC_W-1:0]  pc;
   logic [SP_W-1:0]  sp;
   logic [PC_W-1:0]  ret_stack [STACK_DEPTH];
   logic [IDX_W-1:0] push_idx;
   logic [IDX_W-1:0] pop_idx;
   logic             stack_full;
   logic             stack_empty;

   assign push_idx    = IDX_W'(sp);
   assign pop_idx     = IDX_W'(sp - SP_W'(1));
   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp == '0);

   assign o_req          = (state == S_REQ);
   assign o_prog_counter = pc;
   assign o_stack_level  = sp;

   // Fetch FSM, PC and return stack; idle_state overrides both fetch and exec work
   always_ff @(posedge clk) begin
      if (i_reset) begin
         state             <= S_IDLE;
         pc                <= '0;
         sp                <= '0;
         decode_reg        <= '0;
         fetch_done        <= 1'b0;
         o_stack_overflow  <= 1'b0;
         o_stack_underflow <= 1'b0;
      end else begin
         fetch_done <= 1'b0;
         if (idle_state) begin
            state      <= S_IDLE;
            pc         <= '0;
            sp         <= '0;
            decode_reg <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  // fetch_done gates the still-high fetch_state so requests never run back to back
                  if (fetch_state && !fetch_done) begin
                     state <= S_REQ;
                  end
                  if (exec_state) begin
                     if (jump) begin
                        pc <= const_K;
                     end else if (call) begin
                        pc <= const_K;
                        if (stack_full) begin
                           o_stack_overflow <= 1'b1;
                        end else begin
                           ret_stack[push_idx] <= pc;
                           sp                  <= sp + SP_W'(1);
                        end
                     end else if (return_pc) begin
                        if (stack_empty) begin
                           o_stack_underflow <= 1'b1;
                        end else begin
                           pc <= ret_stack[pop_idx];
                           sp <= sp - SP_W'(1);
                        end
                     end
                  end
               end
               S_REQ: begin
                  if (i_ack) begin
                     decode_reg <= i_instruction;
                     pc         <= pc + PC_W'(1);
                     fetch_done <= 1'b1;
                     state      <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mest_pro_fetch_stack.sv
// Self-checking bench for mest_pro_fetch_stack: fetch timing, wait states, call/return stack,
// sticky flags, strobe priority, PC wrap and idle/reset aborts of an in-flight request.
module tb_mest_pro_fetch_stack;

   localparam int unsigned IW    = 28;
   localparam int unsigned PC_W  = 8;
   localparam int unsigned SP_W  = 3;
   localparam int unsigned DEPTH = 4;

   logic            clk = 1'b0;
   logic            i_reset, idle_state, fetch_state, exec_state;
   logic            jump, call, return_pc, i_ack;
   logic [PC_W-1:0] const_K;
   logic [IW-1:0]   i_instruction;
   logic [IW-1:0]   decode_reg;
   logic            fetch_done, o_stack_overflow, o_stack_underflow, o_req;
   logic [SP_W-1:0] o_stack_level;
   logic [PC_W-1:0] o_prog_counter;

   always #5 clk = ~clk;

   mest_pro_fetch_stack #(
      .OP_CODE_SIZE(4),
      .ROM_DEPTH(256),
      .STACK_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .i_reset(i_reset),
      .idle_state(idle_state),
      .fetch_state(fetch_state),
      .exec_state(exec_state),
      .jump(jump),
      .call(call),
      .return_pc(return_pc),
      .const_K(const_K),
      .decode_reg(decode_reg),
      .fetch_done(fetch_done),
      .o_stack_level(o_stack_level),
      .o_stack_overflow(o_stack_overflow),
      .o_stack_underflow(o_stack_underflow),
      .o_req(o_req),
      .o_prog_counter(o_prog_counter),
      .i_ack(i_ack),
      .i_instruction(i_instruction)
   );

   int              n_checks = 0;
   int              n_fail   = 0;
   logic [IW-1:0]   exp_q [$];
   logic [PC_W-1:0] exp_pc;
   logic [SP_W-1:0] exp_sp;
   logic [PC_W-1:0] mstk [8];
   logic            exp_ovf, exp_unf;

   // ROM content: address 0 -> 0x1000001, 1 -> 0x2000002, 2 -> 0x3000003, ...
   function automatic logic [IW-1:0] rom(input logic [PC_W-1:0] a);
      logic [7:0] b;
      b = a + 8'd1;
      return {b[3:0], 16'h0000, b};
   endfunction

   task automatic do_fetch(input int delay);
      logic [IW-1:0] exp_instr;
      @(negedge clk) fetch_state = 1'b1;
      @(posedge clk) #1;
      exp_q.push_back(rom(exp_pc));
      n_checks++;
      if (o_req !== 1'b1 || o_prog_counter !== exp_pc) begin
         n_fail++;
         $display("FAIL fetch_req: req=%b addr=%h, want req=1 addr=%h", o_req, o_prog_counter, exp_pc);
      end
      for (int k = 0; k < delay; k++) begin
         @(negedge clk) i_ack = 1'b0;
         @(posedge clk) #1;
         n_checks++;
         if (o_req !== 1'b1 || o_prog_counter !== exp_pc || fetch_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait%0d: req=%b addr=%h done=%b, want req=1 addr=%h done=0",
                     k, o_req, o_prog_counter, fetch_done, exp_pc);
         end
      end
      @(negedge clk) begin i_ack = 1'b1; i_instruction = rom(o_prog_counter); end
      @(posedge clk) #1;
      exp_pc++;
      n_checks++;
      if (fetch_done !== 1'b1 || o_req !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_done: done=%b req=%b, want done=1 req=0", fetch_done, o_req);
      end
      exp_instr = exp_q.pop_front();
      n_checks++;
      if (decode_reg !== exp_instr || o_prog_counter !== exp_pc) begin
         n_fail++;
         $display("FAIL fetch_data: decode=%h pc=%h, want decode=%h pc=%h",
                  decode_reg, o_prog_counter, exp_instr, exp_pc);
      end
      @(negedge clk) begin fetch_state = 1'b0; i_ack = 1'b0; i_instruction = '0; end
      @(posedge clk) #1;
      n_checks++;
      if (fetch_done !== 1'b0 || o_req !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_after: done=%b req=%b, want both 0", fetch_done, o_req);
      end
   endtask

   task automatic do_exec(input logic j, input logic c, input logic r, input logic [PC_W-1:0] k);
      @(negedge clk) begin exec_state = 1'b1; jump = j; call = c; return_pc = r; const_K = k; end
      if (j) begin
         exp_pc = k;
      end else if (c) begin
         if (exp_sp == SP_W'(DEPTH)) exp_ovf = 1'b1;
         else begin mstk[exp_sp] = exp_pc; exp_sp++; end
         exp_pc = k;
      end else if (r) begin
         if (exp_sp == '0) exp_unf = 1'b1;
         else begin exp_sp--; exp_pc = mstk[exp_sp]; end
      end
      @(posedge clk) #1;
      n_checks++;
      if (o_prog_counter !== exp_pc || o_stack_level !== exp_sp ||
          o_stack_overflow !== exp_ovf || o_stack_underflow !== exp_unf) begin
         n_fail++;
         $display("FAIL exec j%b c%b r%b: pc=%h lvl=%0d ovf=%b unf=%b, want pc=%h lvl=%0d ovf=%b unf=%b",
                  j, c, r, o_prog_counter, o_stack_level, o_stack_overflow, o_stack_underflow,
                  exp_pc, exp_sp, exp_ovf, exp_unf);
      end
      @(negedge clk) begin exec_state = 1'b0; jump = 1'b0; call = 1'b0; return_pc = 1'b0; end
   endtask

   task automatic test_reset();
      i_reset = 1'b1; idle_state = 1'b0; fetch_state = 1'b0; exec_state = 1'b0;
      jump = 1'b0; call = 1'b0; return_pc = 1'b0; const_K = '0; i_ack = 1'b0; i_instruction = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (o_prog_counter !== '0 || decode_reg !== '0 || fetch_done !== 1'b0 || o_req !== 1'b0 ||
          o_stack_level !== '0 || o_stack_overflow !== 1'b0 || o_stack_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: pc=%h dec=%h done=%b req=%b lvl=%0d ovf=%b unf=%b, want all 0",
                  o_prog_counter, decode_reg, fetch_done, o_req, o_stack_level,
                  o_stack_overflow, o_stack_underflow);
      end
      @(negedge clk) i_reset = 1'b0;
      exp_pc = '0; exp_sp = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
   endtask

   task automatic test_zero_wait();
      for (int i = 0; i < 3; i++) do_fetch(0);
      n_checks++;
      if (o_prog_counter !== 8'h03 || decode_reg !== 28'h3000003) begin
         n_fail++;
         $display("FAIL zero_wait_final: pc=%h dec=%h, want pc=03 dec=3000003", o_prog_counter, decode_reg);
      end
   endtask

   task automatic test_wait_states();
      do_exec(1'b1, 1'b0, 1'b0, 8'h05);
      do_fetch(3);
      n_checks++;
      if (o_prog_counter !== 8'h06 || decode_reg !== 28'h6000006) begin
         n_fail++;
         $display("FAIL wait_final: pc=%h dec=%h, want pc=06 dec=6000006", o_prog_counter, decode_reg);
      end
   endtask

   task automatic test_call_return();
      logic [PC_W-1:0] ret_exp [4];
      ret_exp = '{8'h32, 8'h22, 8'h12, 8'h02};
      do_exec(1'b1, 1'b0, 1'b0, 8'h01);
      do_fetch(0);
      for (int i = 1; i <= 4; i++) begin
         do_exec(1'b0, 1'b1, 1'b0, 8'(i * 16));
         if (i < 4) begin do_fetch(0); do_fetch(0); end
      end
      n_checks++;
      if (o_stack_level !== 3'd4 || o_prog_counter !== 8'h40) begin
         n_fail++;
         $display("FAIL call_depth: lvl=%0d pc=%h, want lvl=4 pc=40", o_stack_level, o_prog_counter);
      end
      for (int i = 0; i < 4; i++) begin
         do_exec(1'b0, 1'b0, 1'b1, 8'h00);
         n_checks++;
         if (o_prog_counter !== ret_exp[i] || o_stack_level !== 3'(3 - i)) begin
            n_fail++;
            $display("FAIL return%0d: pc=%h lvl=%0d, want pc=%h lvl=%0d",
                     i, o_prog_counter, o_stack_level, ret_exp[i], 3 - i);
         end
      end
   endtask

   task automatic test_overflow_underflow();
      do_exec(1'b0, 1'b0, 1'b1, 8'h00);
      n_checks++;
      if (o_stack_underflow !== 1'b1 || o_prog_counter !== 8'h02 || o_stack_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL underflow: unf=%b ovf=%b pc=%h, want unf=1 ovf=0 pc=02",
                  o_stack_underflow, o_stack_overflow, o_prog_counter);
      end
      for (int i = 0; i < 4; i++) do_exec(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
      do_exec(1'b0, 1'b1, 1'b0, 8'h55);
      n_checks++;
      if (o_stack_overflow !== 1'b1 || o_stack_level !== 3'd4 || o_prog_counter !== 8'h55) begin
         n_fail++;
         $display("FAIL overflow: ovf=%b lvl=%0d pc=%h, want ovf=1 lvl=4 pc=55",
                  o_stack_overflow, o_stack_level, o_prog_counter);
      end
      @(negedge clk) idle_state = 1'b1;
      @(posedge clk) #1;
      @(negedge clk) idle_state = 1'b0;
      exp_pc = '0; exp_sp = '0;
      n_checks++;
      if (o_stack_overflow !== 1'b1 || o_stack_underflow !== 1'b1 ||
          o_stack_level !== '0 || o_prog_counter !== '0 || decode_reg !== '0) begin
         n_fail++;
         $display("FAIL idle_sticky: ovf=%b unf=%b lvl=%0d pc=%h dec=%h, want ovf=1 unf=1 lvl=0 pc=0 dec=0",
                  o_stack_overflow, o_stack_underflow, o_stack_level, o_prog_counter, decode_reg);
      end
   endtask

   task automatic test_priority();
      do_exec(1'b0, 1'b1, 1'b0, 8'h10);
      do_exec(1'b1, 1'b1, 1'b1, 8'h7F);
      n_checks++;
      if (o_prog_counter !== 8'h7F || o_stack_level !== 3'd1) begin
         n_fail++;
         $display("FAIL priority: pc=%h lvl=%0d, want pc=7f lvl=1", o_prog_counter, o_stack_level);
      end
   endtask

   task automatic test_wrap();
      do_exec(1'b1, 1'b0, 1'b0, 8'hFF);
      do_fetch(1);
      n_checks++;
      if (o_prog_counter !== 8'h00 || decode_reg !== 28'h0000000) begin
         n_fail++;
         $display("FAIL wrap: pc=%h dec=%h, want pc=00 dec=0000000", o_prog_counter, decode_reg);
      end
   endtask

   task automatic test_idle_abort();
      do_exec(1'b0, 1'b1, 1'b0, 8'h33);
      do_fetch(0);
      @(negedge clk) fetch_state = 1'b1;
      @(posedge clk) #1;
      @(negedge clk) begin idle_state = 1'b1; i_ack = 1'b1; i_instruction = 28'hABCDEF1; end
      @(posedge clk) #1;
      n_checks++;
      if (decode_reg !== '0 || o_prog_counter !== '0 || o_stack_level !== '0 ||
          fetch_done !== 1'b0 || o_req !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_abort: dec=%h pc=%h lvl=%0d done=%b req=%b, want all 0",
                  decode_reg, o_prog_counter, o_stack_level, fetch_done, o_req);
      end
      @(negedge clk) begin idle_state = 1'b0; fetch_state = 1'b0; i_ack = 1'b0; i_instruction = '0; end
      @(posedge clk) #1;
      exp_pc = '0; exp_sp = '0;
      n_checks++;
      if (fetch_done !== 1'b0 || decode_reg !== '0) begin
         n_fail++;
         $display("FAIL idle_abort_late: done=%b dec=%h, want done=0 dec=0", fetch_done, decode_reg);
      end
   endtask

   task automatic test_reset_abort();
      do_exec(1'b1, 1'b0, 1'b0, 8'h20);
      @(negedge clk) fetch_state = 1'b1;
      @(posedge clk) #1;
      @(negedge clk) i_reset = 1'b1;
      @(posedge clk) #1;
      n_checks++;
      if (o_req !== 1'b0 || o_prog_counter !== '0 || o_stack_overflow !== 1'b0 || o_stack_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abort: req=%b pc=%h ovf=%b unf=%b, want all 0",
                  o_req, o_prog_counter, o_stack_overflow, o_stack_underflow);
      end
      @(negedge clk) begin i_reset = 1'b0; fetch_state = 1'b0; i_ack = 1'b1; i_instruction = 28'h1234567; end
      @(posedge clk) #1;
      n_checks++;
      if (fetch_done !== 1'b0 || decode_reg !== '0 || o_prog_counter !== '0) begin
         n_fail++;
         $display("FAIL reset_late_ack: done=%b dec=%h pc=%h, want all 0", fetch_done, decode_reg, o_prog_counter);
      end
      @(negedge clk) i_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_call_return();
      test_overflow_underflow();
      test_priority();
      test_wrap();
      test_idle_abort();
      test_reset_abort();
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_leftover: %0d entries, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
